// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: store request, load probe and data-memory write port.
// The buffer uses the slave modport; the pipeline/memory side uses master.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be, st_pc, ld_valid, ld_addr, dm_ready,
    output st_ready, ld_stall, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_be, st_pc, ld_valid, ld_addr, dm_ready,
    input  st_ready, ld_stall, dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between EX/MEM and data memory, one drain per cycle.
// Define STORE_BUFFER_MERGE_EN to merge same-word pushes into the tail entry.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 30
) (
  input logic            clk,
  input logic            reset,
  store_buffer_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
    logic [31:0]   pc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    tail;
  logic [AW-1:0]    st_word;
  logic [AW-1:0]    ld_word;
  logic [31:0]      merged_data;
  logic             push_any;
  logic             alloc;
  logic             pop;
  logic             merge;
  logic             hit;
  logic             unused_low_bits;

  assign st_word         = bus.st_addr[AW+1:2];
  assign ld_word         = bus.ld_addr[AW+1:2];
  assign unused_low_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
  assign tail            = wr_ptr - PW'(1);

`ifdef STORE_BUFFER_MERGE_EN
  // Merge only into a tail that is not leaving this cycle.
  assign merge = bus.st_valid && (bus.st_be != 4'h0) && (count != CW'(0)) &&
                 (st_word == mem[tail].addr) && !(pop && (count == CW'(1)));
`else
  assign merge = 1'b0;
`endif

  assign bus.st_ready = (count < CW'(DEPTH)) || merge;
  assign pop          = (count != CW'(0)) && bus.dm_ready;
  assign push_any     = bus.st_valid && bus.st_ready && (bus.st_be != 4'h0);
  assign alloc        = push_any && !merge;

  assign bus.dm_we   = pop;
  assign bus.dm_addr = 32'({mem[rd_ptr].addr, 2'b00});
  assign bus.dm_wd   = mem[rd_ptr].data;
  assign bus.dm_be   = mem[rd_ptr].be;
  assign bus.dm_pc   = mem[rd_ptr].pc;
  assign bus.empty   = (count == CW'(0));

  // Word-granular hazard check against pending entries and the incoming store.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (mem[i].addr == ld_word)) hit = 1'b1;
    end
    if (push_any && (st_word == ld_word)) hit = 1'b1;
  end

  assign bus.ld_stall = bus.ld_valid && hit;

  always_comb begin
    merged_data = mem[tail].data;
    for (int i = 0; i < 4; i++) begin
      if (bus.st_be[i]) merged_data[8*i +: 8] = bus.st_wdata[8*i +: 8];
    end
  end

  // Entry payload storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem[wr_ptr] <= '{addr: st_word, data: bus.st_wdata, be: bus.st_be, pc: bus.st_pc};
    end else if (merge) begin
      mem[tail] <= '{addr: mem[tail].addr, data: merged_data,
                     be: mem[tail].be | bus.st_be, pc: bus.st_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= CW'(0);
      rd_ptr <= PW'(0);
      wr_ptr <= PW'(0);
      valid  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (alloc) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  ent_t q[$];

  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH), .AW(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [3:0] sbe, input logic [31:0] spc,
                      input logic lv, input logic [31:0] la,
                      input logic dr, input logic rst);
    int   n;
    logic merge_exp, rdy_exp, acc, we_exp, hit;
    ent_t e;
    @(negedge clk);
    reset       = rst;
    sb.st_valid = sv;
    sb.st_addr  = sa;
    sb.st_wdata = sd;
    sb.st_be    = sbe;
    sb.st_pc    = spc;
    sb.ld_valid = lv;
    sb.ld_addr  = la;
    sb.dm_ready = dr;
    #1;
    n         = q.size();
    merge_exp = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
    merge_exp = sv && (sbe != 4'h0) && (n > 0) && (sa[31:2] == q[n-1].a) && !(dr && n == 1);
`endif
    rdy_exp = (n < DEPTH) || merge_exp;
    acc     = sv && rdy_exp && (sbe != 4'h0);
    we_exp  = (n > 0) && dr;
    hit     = 1'b0;
    foreach (q[i]) if (q[i].a == la[31:2]) hit = 1'b1;
    if (acc && (sa[31:2] == la[31:2])) hit = 1'b1;
    chk("st_ready", 32'(sb.st_ready), 32'(rdy_exp));
    chk("dm_we",    32'(sb.dm_we),    32'(we_exp));
    chk("empty",    32'(sb.empty),    32'(n == 0));
    chk("ld_stall", 32'(sb.ld_stall), 32'(lv && hit));
    if (n > 0) begin
      chk("dm_addr", sb.dm_addr, {q[0].a, 2'b00});
      chk("dm_wd",   sb.dm_wd,   q[0].d);
      chk("dm_be",   32'(sb.dm_be), 32'(q[0].be));
      chk("dm_pc",   sb.dm_pc,   q[0].pc);
    end
    if (rst) begin
      q.delete();
    end else begin
      if (merge_exp) begin
        e = q[n-1];
        for (int b = 0; b < 4; b++) if (sbe[b]) e.d[8*b +: 8] = sd[8*b +: 8];
        e.be     = e.be | sbe;
        e.pc     = spc;
        q[n-1]   = e;
      end
      if (we_exp) void'(q.pop_front());
      if (acc && !merge_exp) begin
        e.a  = sa[31:2];
        e.d  = sd;
        e.be = sbe;
        e.pc = spc;
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic dr, input logic lv, input logic [31:0] la);
    step(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, lv, la, dr, 1'b0);
  endtask

  task automatic store(input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sbe,
                       input logic dr);
    step(1'b1, sa, sd, sbe, sa + 32'h1000, 1'b0, 32'h0, dr, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    step(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    #2;
    chk("rst_empty",    32'(sb.empty),    32'd1);
    chk("rst_st_ready", 32'(sb.st_ready), 32'd1);
    chk("rst_dm_we",    32'(sb.dm_we),    32'd0);

    // Single store drains one cycle after acceptance.
    store(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    #2;
    chk("tp1_we",   32'(sb.dm_we), 32'd1);
    chk("tp1_addr", sb.dm_addr,    32'h10);
    chk("tp1_wd",   sb.dm_wd,      32'hDEADBEEF);
    idle(1'b1, 1'b0, 32'h0);
    #2;
    chk("tp1_empty", 32'(sb.empty), 32'd1);

    // Fill, refuse a fifth, then drain in order.
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1'b0);
    store(32'h40, 32'h55, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0, 32'h0);

    // Load hazard against a same-cycle push and a pending entry.
    step(1'b1, 32'h20, 32'h1234, 4'hF, 32'h20, 1'b1, 32'h22, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 32'h24);
    idle(1'b1, 1'b1, 32'h22);
    idle(1'b1, 1'b1, 32'h22);
    idle(1'b1, 1'b1, 32'h24);

    // Zero byte-enable store is accepted but allocates nothing.
    step(1'b1, 32'h50, 32'h0, 4'h0, 32'h0, 1'b1, 32'h50, 1'b0, 1'b0);

    // Steady state at count 2 with simultaneous push and pop, wrapping pointers.
    store(32'h100, 32'h1, 4'hF, 1'b0);
    store(32'h104, 32'h2, 4'hF, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) store(32'h200 + 32'(i * 4), 32'h100 + 32'(i), 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 32'h0);

    // Reset with entries pending discards them.
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(i * 4), 32'h77, 4'hF, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    #2;
    chk("rstmid_we",    32'(sb.dm_we),    32'd0);
    chk("rstmid_empty", 32'(sb.empty),    32'd1);
    chk("rstmid_ready", 32'(sb.st_ready), 32'd1);
    idle(1'b1, 1'b1, 32'h300);

`ifdef STORE_BUFFER_MERGE_EN
    store(32'h30, 32'h000000AA, 4'b0001, 1'b0);
    store(32'h30, 32'h0000BB00, 4'b0010, 1'b0);
    #2;
    chk("merge_wd", sb.dm_wd, 32'h0000BBAA);
    chk("merge_be", 32'(sb.dm_be), 32'h3);
    idle(1'b1, 1'b0, 32'h0);
    #2;
    chk("merge_cnt1", 32'(sb.empty), 32'd1);
`endif

    // Random traffic over a small address pool to provoke hits and merges.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 7),
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
           $urandom(), 4'($urandom_range(0, 15)), $urandom(),
           1'($urandom_range(0, 1)),
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
